// File: rtl/mem_stage_lsu_if.sv
// LSU data bus: registered request/ack handshake carrying a word
// address, byte strobes and lane-shifted write data.
interface mem_stage_lsu_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr,
    output bus_wstrb, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr,
    input  bus_wstrb, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: B/H/W accesses over req/ack, stalls upstream.
// Optional bus-wait timeout enabled by defining LSU_TIMEOUT_EN.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [31:0]           store_data,
  output logic                  stall,
  output logic [31:0]           load_data,
  output logic                  fault,
  mem_stage_lsu_if.master       bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic        access, bad;
  logic        f3_ill, h_mis, w_mis;
  logic        tmo_hit;
  logic        req_d, we_d, fault_d;
  logic [31:0] addr_d, wdata_d, ld_d;
  logic [3:0]  strb_d;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] rd_fmt;

  assign access = mem_read | mem_write;
  assign f3_ill = funct3 inside {3'b011, 3'b110, 3'b111};
  assign h_mis  = (funct3[1:0] == 2'b01) & addr[0];
  assign w_mis  = (funct3 == 3'b010) & (addr[1:0] != 2'b00);
  assign bad    = (mem_read & mem_write) | f3_ill
                | (mem_write & funct3[2]) | h_mis | w_mis;

  always_comb begin
    st_strb = 4'b0000;
    st_data = 32'h0;
    unique case (funct3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << addr[1:0];
        st_data = {4{store_data[7:0]}};
      end
      2'b01: begin
        st_strb = addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{store_data[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = store_data;
      end
    endcase
  end

  // Only legal encodings are latched: W has bit1 set, H/HU bit0.
  always_comb begin
    byte_v = bus.bus_rdata[{lane_q, 3'b000} +: 8];
    half_v = lane_q[1] ? bus.bus_rdata[31:16]
                       : bus.bus_rdata[15:0];
    rd_fmt = 32'h0;
    unique case (1'b1)
      f3_q[1]: rd_fmt = bus.bus_rdata;
      f3_q[0]: rd_fmt = {{16{~f3_q[2] & half_v[15]}}, half_v};
      default: rd_fmt = {{24{~f3_q[2] & byte_v[7]}}, byte_v};
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr || state_q != BUSY) cnt_q <= '0;
    else                        cnt_q <= cnt_q + 1'b1;
  end

  assign tmo_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  wire unused_tmo = |TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    req_d   = bus.bus_req;
    we_d    = bus.bus_we;
    addr_d  = bus.bus_addr;
    strb_d  = bus.bus_wstrb;
    wdata_d = bus.bus_wdata;
    ld_d    = load_data;
    fault_d = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access && bad) begin
          fault_d = 1'b1;
          ld_d    = 32'h0;
        end else if (access) begin
          stall   = 1'b1;
          state_d = BUSY;
          f3_d    = funct3;
          lane_d  = addr[1:0];
          req_d   = 1'b1;
          we_d    = mem_write;
          addr_d  = {addr[31:2], 2'b00};
          strb_d  = mem_write ? st_strb : 4'b0000;
          wdata_d = mem_write ? st_data : 32'h0;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (bus.bus_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          ld_d    = bus.bus_we ? 32'h0 : rd_fmt;
          state_d = DONE;
        end else if (tmo_hit) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          ld_d    = 32'h0;
          fault_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= IDLE;
      f3_q          <= 3'b000;
      lane_q        <= 2'b00;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 32'h0;
      bus.bus_wstrb <= 4'b0000;
      bus.bus_wdata <= 32'h0;
      load_data     <= 32'h0;
      fault         <= 1'b0;
    end else begin
      state_q       <= state_d;
      f3_q          <= f3_d;
      lane_q        <= lane_d;
      bus.bus_req   <= req_d;
      bus.bus_we    <= we_d;
      bus.bus_addr  <= addr_d;
      bus.bus_wstrb <= strb_d;
      bus.bus_wdata <= wdata_d;
      load_data     <= ld_d;
      fault         <= fault_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: queued bus and result
// expectations, a bus responder and a result monitor.
module tb_mem_stage_lsu;
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        stall;
  logic [31:0] load_data;
  logic        fault;
  logic        rsp_ack = 1'b0;
  logic        inj_ack = 1'b0;
  logic [31:0] rsp_rdata = 32'h0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
  } bus_t;

  typedef struct {
    logic        fault;
    logic [31:0] ld;
    int          stalls;
  } res_t;

  bus_t bus_q[$];
  res_t res_q[$];

  mem_stage_lsu_if bus ();

  assign bus.bus_ack   = rsp_ack | inj_ack;
  assign bus.bus_rdata = rsp_rdata;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .clr        (clr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .load_data  (load_data),
    .fault      (fault),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  // Bus responder: checks each new request, acks after lat BUSY cycles.
  initial begin : responder
    static bit in_txn = 0;
    static int cnt = 0;
    static bus_t cur;
    forever begin
      @(negedge clk);
      rsp_ack = 1'b0;
      if (bus.bus_req) begin
        if (!in_txn) begin
          in_txn = 1;
          cnt = 0;
          if (bus_q.size() == 0) begin
            cur = '{0, 0, 0, 0, 0, 0};
            chk("unexpected_bus_req", 1, 0);
          end else begin
            cur = bus_q.pop_front();
            chk("bus_we", bus.bus_we, cur.we);
            chk("bus_addr", bus.bus_addr, cur.addr);
            chk("bus_wstrb", bus.bus_wstrb, cur.strb);
            if (cur.we) chk("bus_wdata", bus.bus_wdata, cur.wdata);
          end
        end
        cnt++;
        if (cur.lat != 0 && cnt == cur.lat) begin
          rsp_ack = 1'b1;
          rsp_rdata = cur.rdata;
        end
      end else begin
        in_txn = 0;
      end
    end
  end

  // Result monitor: an access completes when stall falls or fault pulses.
  initial begin : monitor
    static int scnt = 0;
    static res_t e;
    forever begin
      @(negedge clk);
      if (stall) begin
        scnt++;
      end else if (scnt != 0 || fault) begin
        if (res_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = res_q.pop_front();
          chk("fault", fault, e.fault);
          chk("load_data", load_data, e.ld);
          chk("stall_cycles", scnt, e.stalls);
        end
        scnt = 0;
      end
    end
  end

  task automatic issue(input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd);
    bit ok;
    @(posedge clk); #1;
    mem_read = rd;
    mem_write = wr;
    funct3 = f3;
    addr = a;
    store_data = sd;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!stall) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("stall_timeout", 1, 0);
    @(posedge clk); #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] rd, input int lat,
                    input logic [31:0] exp);
    bus_q.push_back('{1'b0, {a[31:2], 2'b00}, 4'b0000, 32'h0, lat, rd});
    res_q.push_back('{1'b0, exp, 1 + lat});
    issue(1'b1, 1'b0, f3, a, 32'h0);
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] sd, input logic [3:0] strb,
                    input logic [31:0] wd, input int lat);
    bus_q.push_back('{1'b1, {a[31:2], 2'b00}, strb, wd, lat, 32'h0});
    res_q.push_back('{1'b0, 32'h0, 1 + lat});
    issue(1'b0, 1'b1, f3, a, sd);
  endtask

  task automatic bad(input logic rd, input logic wr,
                     input logic [2:0] f3, input logic [31:0] a);
    res_q.push_back('{1'b1, 32'h0, 0});
    issue(rd, wr, f3, a, 32'h0000_5678);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_fault", fault, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_bus_req", bus.bus_req, 0);
    chk("rst_bus_we", bus.bus_we, 0);
    chk("rst_bus_addr", bus.bus_addr, 0);
    chk("rst_bus_wstrb", bus.bus_wstrb, 0);
    chk("rst_bus_wdata", bus.bus_wdata, 0);

    ld(3'b010, 32'h100, 32'hDEADBEEF, 2, 32'hDEADBEEF);
    ld(3'b000, 32'h103, 32'h80123456, 1, 32'hFFFFFF80);
    ld(3'b100, 32'h103, 32'h80123456, 1, 32'h00000080);
    ld(3'b101, 32'h102, 32'h80123456, 1, 32'h00008012);
    ld(3'b001, 32'h102, 32'h80123456, 3, 32'hFFFF8012);
    st(3'b000, 32'h201, 32'h000000AB, 4'b0010, 32'hABABABAB, 1);
    st(3'b001, 32'h202, 32'h00001234, 4'b1100, 32'h12341234, 3);
    st(3'b010, 32'h204, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 1);
    ld(3'b000, 32'h101, 32'h80123456, 1, 32'h00000034);
    bad(1'b1, 1'b0, 3'b010, 32'h102);
    bad(1'b0, 1'b1, 3'b100, 32'h200);
    bad(1'b1, 1'b1, 3'b010, 32'h200);
    bad(1'b1, 1'b0, 3'b011, 32'h200);
    bad(1'b1, 1'b0, 3'b101, 32'h203);
    ld(3'b010, 32'h104, 32'h13579BDF, 1, 32'h13579BDF);

    bus_q.push_back('{1'b0, 32'h300, 4'b0000, 32'h0, 3, 32'h11111111});
    res_q.push_back('{1'b0, 32'h0, 2});
    @(posedge clk); #1;
    mem_read = 1'b1;
    funct3 = 3'b010;
    addr = 32'h300;
    @(posedge clk); #1;
    clr = 1'b1;
    mem_read = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0;
    inj_ack = 1'b1;
    @(negedge clk);
    chk("clr_bus_req", bus.bus_req, 0);
    chk("clr_stall", stall, 0);
    @(posedge clk); #1;
    inj_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("clr_fault", fault, 0);
    chk("clr_load_data", load_data, 0);
    chk("clr_bus_req_late", bus.bus_req, 0);

    ld(3'b010, 32'h108, 32'h2468ACE0, 1, 32'h2468ACE0);

`ifdef LSU_TIMEOUT_EN
    bus_q.push_back('{1'b0, 32'h10C, 4'b0000, 32'h0, 0, 32'h0});
    res_q.push_back('{1'b1, 32'h0, 5});
    issue(1'b1, 1'b0, 3'b010, 32'h10C, 32'h0);
`endif

    repeat (4) @(posedge clk);
    chk("res_q_empty", res_q.size(), 0);
    chk("bus_q_empty", bus_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
